// File: rtl/vga_framebuffer_reader_pkg.sv
// Shared VGA 640x480@60 timing constants, frame-buffer geometry and RGB332 helpers
// for the frame-buffer read side.
package vga_framebuffer_reader_pkg;

   localparam int H_ACTIVE       = 640;
   localparam int H_FP           = 16;
   localparam int H_SYNC         = 96;
   localparam int H_BP           = 48;
   localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START   = H_ACTIVE + H_FP;
   localparam int H_SYNC_END     = H_SYNC_START + H_SYNC - 1;

   localparam int V_ACTIVE       = 480;
   localparam int V_FP           = 10;
   localparam int V_SYNC         = 2;
   localparam int V_BP           = 33;
   localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START   = V_ACTIVE + V_FP;
   localparam int V_SYNC_END     = V_SYNC_START + V_SYNC - 1;

   localparam int FB_W           = 320;
   localparam int FB_H           = 240;
   localparam int FB_SIZE        = FB_W * FB_H;
   localparam int ADDR_W         = 17;
   localparam int SCALE          = 2;
   localparam int SCALE_LOG2     = 1;
   localparam int CNT_W          = 10;

   localparam int R_MSB = 7, R_LSB = 5;
   localparam int G_MSB = 4, G_LSB = 2;
   localparam int B_MSB = 1, B_LSB = 0;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic frame_start;
   } vflags_t;

   // Replicate the top bits so full-scale RGB332 maps to full-scale 4-bit DAC codes.
   function automatic rgb444_t rgb332_expand(input logic [7:0] d);
      rgb444_t c;
      c.r = {d[R_MSB:R_LSB], d[R_MSB]};
      c.g = {d[G_MSB:G_LSB], d[G_MSB]};
      c.b = {d[B_MSB:B_LSB], d[B_MSB:B_LSB]};
      return c;
   endfunction

endpackage

// File: rtl/vga_framebuffer_reader_if.sv
// DP_RAM read port as seen from the frame-buffer reader (master) and the RAM (slave).
interface vga_framebuffer_reader_if;
   import vga_framebuffer_reader_pkg::*;

   logic [ADDR_W-1:0] DP_RAM_addr_out;
   logic              DP_RAM_regR;
   logic [7:0]        DP_RAM_data_out;

   modport master (output DP_RAM_addr_out, output DP_RAM_regR, input DP_RAM_data_out);
   modport slave  (input DP_RAM_addr_out, input DP_RAM_regR, output DP_RAM_data_out);
endinterface

// File: rtl/vga_framebuffer_reader_timing.sv
// VGA raster counters and stage-0 flags; also exposes next-cycle values so the
// address register can present the address of the current counter position.
module vga_timing_gen
   import vga_framebuffer_reader_pkg::*;
#(
   parameter int H_ACTIVE_P = H_ACTIVE,
   parameter int H_FP_P     = H_FP,
   parameter int H_SYNC_P   = H_SYNC,
   parameter int H_BP_P     = H_BP,
   parameter int V_ACTIVE_P = V_ACTIVE,
   parameter int V_FP_P     = V_FP,
   parameter int V_SYNC_P   = V_SYNC,
   parameter int V_BP_P     = V_BP
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic [CNT_W-1:0] vcnt_o,
   output logic [CNT_W-1:0] hcnt_next_o,
   output logic             active_next_o,
   output logic             line_end_o,
   output logic             frame_end_o,
   output logic             active_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             frame_start_o
);
   localparam int H_TOT = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
   localparam int V_TOT = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE_P);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE_P);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE_P + H_FP_P);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE_P + H_FP_P + H_SYNC_P - 1);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE_P + V_FP_P);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE_P + V_FP_P + V_SYNC_P - 1);

   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   always_comb begin
      line_end_o  = (hcnt_q == H_LAST);
      frame_end_o = line_end_o && (vcnt_q == V_LAST);
      hcnt_d      = line_end_o ? '0 : hcnt_q + 1'b1;
      vcnt_d      = vcnt_q;
      if (frame_end_o)
         vcnt_d = '0;
      else if (line_end_o)
         vcnt_d = vcnt_q + 1'b1;
   end

   assign vcnt_o        = vcnt_q;
   assign hcnt_next_o   = hcnt_d;
   assign active_next_o = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
   assign active_o      = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
   assign hsync_o       = (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
   assign vsync_o       = (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);
   assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Frame-buffer reader: 2x-upscaled RGB332 fetch from DP_RAM, 2-stage pipeline to
// 12-bit VGA colour with sync and frame-start kept aligned to the pixel data.
module vga_framebuffer_reader
   import vga_framebuffer_reader_pkg::*;
#(
   parameter int H_ACTIVE_P = H_ACTIVE,
   parameter int H_FP_P     = H_FP,
   parameter int H_SYNC_P   = H_SYNC,
   parameter int H_BP_P     = H_BP,
   parameter int V_ACTIVE_P = V_ACTIVE,
   parameter int V_FP_P     = V_FP,
   parameter int V_SYNC_P   = V_SYNC,
   parameter int V_BP_P     = V_BP,
   parameter int FB_W_P     = FB_W
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   vga_framebuffer_reader_if.master        ram,
   output logic [3:0]                      VGA_R,
   output logic [3:0]                      VGA_G,
   output logic [3:0]                      VGA_B,
   output logic                            VGA_Hsync_n,
   output logic                            VGA_Vsync_n,
   output logic                            FRAME_START
);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W_P);
   localparam logic [CNT_W-1:0]  V_VIS     = CNT_W'(V_ACTIVE_P);

   logic [CNT_W-1:0] vcnt, hcnt_next;
   logic             active_next, line_end, frame_end;
   vflags_t          flags0, flags1_q;

   vga_timing_gen #(
      .H_ACTIVE_P(H_ACTIVE_P), .H_FP_P(H_FP_P), .H_SYNC_P(H_SYNC_P), .H_BP_P(H_BP_P),
      .V_ACTIVE_P(V_ACTIVE_P), .V_FP_P(V_FP_P), .V_SYNC_P(V_SYNC_P), .V_BP_P(V_BP_P)
   ) u_timing (
      .clk_i         (CLK),
      .rst_ni        (RST_N),
      .vcnt_o        (vcnt),
      .hcnt_next_o   (hcnt_next),
      .active_next_o (active_next),
      .line_end_o    (line_end),
      .frame_end_o   (frame_end),
      .active_o      (flags0.active),
      .hsync_o       (flags0.hsync),
      .vsync_o       (flags0.vsync),
      .frame_start_o (flags0.frame_start)
   );

   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              regr_q, regr_d;
   rgb444_t           rgb_q;
   logic              hsync_n_q, vsync_n_q, frame_start_q;

   // Address registers are loaded from next-cycle counters, so addr_q always
   // belongs to the counter value currently in stage 0.
   always_comb begin
      line_base_d = line_base_q;
      if (frame_end)
         line_base_d = '0;
      else if (line_end && vcnt[0] && (vcnt < V_VIS))
         line_base_d = line_base_q + LINE_STEP;
      regr_d = active_next;
      addr_d = active_next ? line_base_d + ADDR_W'(hcnt_next >> SCALE_LOG2) : addr_q;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         line_base_q   <= '0;
         addr_q        <= '0;
         regr_q        <= 1'b0;
         flags1_q      <= '0;
         rgb_q         <= '0;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         line_base_q   <= line_base_d;
         addr_q        <= addr_d;
         regr_q        <= regr_d;
         flags1_q      <= flags0;
         rgb_q         <= flags1_q.active ? rgb332_expand(ram.DP_RAM_data_out) : '0;
         hsync_n_q     <= ~flags1_q.hsync;
         vsync_n_q     <= ~flags1_q.vsync;
         frame_start_q <= flags1_q.frame_start;
      end
   end

   assign ram.DP_RAM_addr_out = addr_q;
   assign ram.DP_RAM_regR     = regr_q;
   assign VGA_R               = rgb_q.r;
   assign VGA_G               = rgb_q.g;
   assign VGA_B               = rgb_q.b;
   assign VGA_Hsync_n         = hsync_n_q;
   assign VGA_Vsync_n         = vsync_n_q;
   assign FRAME_START         = frame_start_q;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench for vga_framebuffer_reader: full horizontal timing with a shortened frame
// height, raster-position reference model, colour vector table and mid-frame reset.
module tb_vga_framebuffer_reader;
   import vga_framebuffer_reader_pkg::*;

   localparam int HA = 640, HFP = 16, HSW = 96, HBP = 48, HT = 800;
   localparam int VA = 16, VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
   localparam int FW = 320, FBSZ = FW * (VA / 2);
   localparam int FRAME = HT * VT;
   localparam int HS_BEG = HA + HFP, HS_END = HA + HFP + HSW - 1;
   localparam int VS_BEG = VA + VFP, VS_END = VA + VFP + VSW - 1;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [3:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_Hsync_n, VGA_Vsync_n, FRAME_START;

   vga_framebuffer_reader_if ram_if ();

   vga_framebuffer_reader #(
      .H_ACTIVE_P(HA), .H_FP_P(HFP), .H_SYNC_P(HSW), .H_BP_P(HBP),
      .V_ACTIVE_P(VA), .V_FP_P(VFP), .V_SYNC_P(VSW), .V_BP_P(VBP), .FB_W_P(FW)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .ram         (ram_if),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_Hsync_n (VGA_Hsync_n),
      .VGA_Vsync_n (VGA_Vsync_n),
      .FRAME_START (FRAME_START)
   );

   always #20 CLK = ~CLK;

   // RAM contents: 0 = low address byte, 1 = constant, 2 = random image
   int         mode = 0;
   logic [7:0] const_data = 8'h00;
   logic [7:0] mem [FBSZ];

   function automatic logic [7:0] ram_byte(input int a);
      if (mode == 0) return 8'(a % 256);
      if (mode == 1) return const_data;
      return (a < FBSZ) ? mem[a] : 8'h00;
   endfunction

   always @(posedge CLK) ram_if.DP_RAM_data_out <= ram_byte(int'(ram_if.DP_RAM_addr_out));

   // cycles since reset release; DUT counter position equals k, pins show k-2
   int k = 0;
   always @(posedge CLK) k <= RST_N ? k + 1 : 0;

   int tests = 0, fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (k=%0d)", name, act, exp, k);
      end
   endtask

   function automatic bit is_active(input int h, input int v);
      return (h < HA) && (v < VA);
   endfunction

   function automatic int pix_addr(input int h, input int v);
      return (v / 2) * FW + h / 2;
   endfunction

   // address still on the bus after the last visible pixel
   function automatic int held_addr(input int h, input int v);
      if (v < VA) return pix_addr(HA - 1, v);
      return pix_addr(HA - 1, VA - 1);
   endfunction

   function automatic logic [11:0] exp_rgb(input int d);
      int r3, g3, b2, rr, gg, bb;
      r3 = d / 32;
      g3 = (d / 4) % 8;
      b2 = d % 4;
      rr = r3 * 2 + r3 / 4;
      gg = g3 * 2 + g3 / 4;
      bb = b2 * 5;
      return 12'(rr * 256 + gg * 16 + bb);
   endfunction

   function automatic logic [32:0] expected_vec(input int kk);
      int h, v, m, hm, vm;
      logic [16:0] ea;
      logic er, hs, vs, fs;
      logic [11:0] rgb;
      h = kk % HT;
      v = (kk / HT) % VT;
      if (kk == 0) begin
         ea = '0; er = 1'b0;
      end else if (is_active(h, v)) begin
         ea = 17'(pix_addr(h, v)); er = 1'b1;
      end else begin
         ea = 17'(held_addr(h, v)); er = 1'b0;
      end
      if (kk < 2) begin
         rgb = '0; hs = 1'b1; vs = 1'b1; fs = 1'b0;
      end else begin
         m  = kk - 2;
         hm = m % HT;
         vm = (m / HT) % VT;
         rgb = is_active(hm, vm) ? exp_rgb(int'(ram_byte(pix_addr(hm, vm)))) : 12'h000;
         hs = !(hm >= HS_BEG && hm <= HS_END);
         vs = !(vm >= VS_BEG && vm <= VS_END);
         fs = (hm == 0) && (vm == 0);
      end
      return {ea, er, rgb, hs, vs, fs};
   endfunction

   function automatic logic [32:0] pins_now();
      return {ram_if.DP_RAM_addr_out, ram_if.DP_RAM_regR, VGA_R, VGA_G, VGA_B,
              VGA_Hsync_n, VGA_Vsync_n, FRAME_START};
   endfunction

   // Continuous monitor: every cycle compared, one counted result per scanline.
   bit          mon_en = 1'b0;
   bit          line_pend = 1'b0, line_bad = 1'b0;
   logic [32:0] first_act, first_exp, last_act, last_exp, mon_act, mon_exp;
   int          first_k = 0;
   int          vs_low = 0, hs_low = 0, fs_cnt = 0;

   task automatic flush_line();
      if (line_pend) begin
         if (line_bad) check($sformatf("stream k0=%0d", first_k), 64'(first_act), 64'(first_exp));
         else          check("stream", 64'(last_act), 64'(last_exp));
      end
      line_pend = 1'b0;
      line_bad  = 1'b0;
   endtask

   always @(negedge CLK) begin
      if (!RST_N) begin
         flush_line();
      end else if (mon_en) begin
         mon_exp = expected_vec(k);
         mon_act = pins_now();
         line_pend = 1'b1;
         last_act = mon_act;
         last_exp = mon_exp;
         if ((mon_act !== mon_exp) && !line_bad) begin
            line_bad  = 1'b1;
            first_act = mon_act;
            first_exp = mon_exp;
            first_k   = k;
         end
         if (k >= 2 && k < 2 + 2 * FRAME) begin
            if (!VGA_Vsync_n) vs_low++;
            if (!VGA_Hsync_n) hs_low++;
            if (FRAME_START)  fs_cnt++;
         end
         if (k % HT == HT - 1) flush_line();
      end
   end

   task automatic wait_counter(input int h, input int v, input string tag);
      bit hit;
      hit = 1'b0;
      repeat (2 * FRAME + 10) begin
         @(negedge CLK);
         if (RST_N && (k % HT == h) && ((k / HT) % VT == v)) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         tests++;
         fails++;
         $display("FAIL timeout %s: position (%0d,%0d) not reached", tag, h, v);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic [3:0] r, g, b;
   } colour_vec_t;

   colour_vec_t tbl [9];
   logic [32:0] reset_vec;

   initial begin
      for (int i = 0; i < FBSZ; i++) mem[i] = 8'($urandom);
      tbl[0] = '{8'hFF, 4'hF, 4'hF, 4'hF};
      tbl[1] = '{8'hE0, 4'hF, 4'h0, 4'h0};
      tbl[2] = '{8'h1C, 4'h0, 4'hF, 4'h0};
      tbl[3] = '{8'h03, 4'h0, 4'h0, 4'hF};
      tbl[4] = '{8'h00, 4'h0, 4'h0, 4'h0};
      for (int i = 5; i < 9; i++) begin
         tbl[i].data = 8'($urandom);
         {tbl[i].r, tbl[i].g, tbl[i].b} = exp_rgb(int'(tbl[i].data));
      end
      reset_vec = {17'd0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0};

      // power-up reset
      RST_N = 1'b0;
      repeat (5) @(negedge CLK);
      check("reset_vec", 64'(pins_now()), 64'(reset_vec));
      RST_N  = 1'b1;
      mon_en = 1'b1;

      // addressing and sync boundaries, first frame (data = addr[7:0])
      wait_counter(1, 0, "h1");
      check("addr_h1", 64'(ram_if.DP_RAM_addr_out), 64'd0);
      check("regR_h1", 64'(ram_if.DP_RAM_regR), 64'd1);
      wait_counter(2, 0, "h2");
      check("addr_h2", 64'(ram_if.DP_RAM_addr_out), 64'd1);
      wait_counter(HS_BEG - 1, 0, "hs");
      repeat (2) @(negedge CLK);
      check("hsync_before", 64'(VGA_Hsync_n), 64'd1);
      @(negedge CLK);
      check("hsync_start", 64'(VGA_Hsync_n), 64'd0);
      wait_counter(0, 2, "line2");
      check("line2_base", 64'(ram_if.DP_RAM_addr_out), 64'(FW));
      wait_counter(HA - 1, VA - 1, "last");
      check("last_addr", 64'(ram_if.DP_RAM_addr_out), 64'(FBSZ - 1));
      @(negedge CLK);
      check("blank_regR", 64'(ram_if.DP_RAM_regR), 64'd0);
      check("blank_hold", 64'(ram_if.DP_RAM_addr_out), 64'(FBSZ - 1));
      wait_counter(100, VA + 1, "vblank");
      mode = 2;

      // frame wrap
      wait_counter(HT - 1, VT - 1, "wrap");
      check("wrap_regR", 64'(ram_if.DP_RAM_regR), 64'd0);
      @(negedge CLK);
      check("wrap_addr", 64'(ram_if.DP_RAM_addr_out), 64'd0);
      check("wrap_regR1", 64'(ram_if.DP_RAM_regR), 64'd1);
      repeat (2) @(negedge CLK);
      check("wrap_fs", 64'(FRAME_START), 64'd1);
      wait_counter(2, 0, "frame3");
      check("vsync_low_cycles", 64'(vs_low), 64'(2 * VSW * HT));
      check("hsync_low_cycles", 64'(hs_low), 64'(2 * VT * HSW));
      check("frame_starts", 64'(fs_cnt), 64'd2);

      // colour expansion table, one entry per scanline
      for (int i = 0; i < 9; i++) begin
         wait_counter(700, 3 + i, "col_set");
         mode = 1;
         const_data = tbl[i].data;
         wait_counter(100, 4 + i, "col_vis");
         repeat (2) @(negedge CLK);
         check($sformatf("col%0d_R", i), 64'(VGA_R), 64'(tbl[i].r));
         check($sformatf("col%0d_G", i), 64'(VGA_G), 64'(tbl[i].g));
         check($sformatf("col%0d_B", i), 64'(VGA_B), 64'(tbl[i].b));
         wait_counter(HA + 5, 4 + i, "col_blank");
         repeat (2) @(negedge CLK);
         check($sformatf("col%0d_blank", i), 64'({VGA_R, VGA_G, VGA_B}), 64'd0);
      end
      wait_counter(700, 13, "img");
      mode = 2;

      // asynchronous reset mid-frame at a random visible column
      wait_counter($urandom_range(0, HA - 1), 14, "mid");
      #2 RST_N = 1'b0;
      #1 check("async_reset", 64'(pins_now()), 64'(reset_vec));
      repeat (5) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      check("fs_k1", 64'(FRAME_START), 64'd0);
      @(negedge CLK);
      check("fs_k2", 64'(FRAME_START), 64'd1);
      check("addr_k2", 64'(ram_if.DP_RAM_addr_out), 64'd1);
      @(negedge CLK);
      check("fs_k3", 64'(FRAME_START), 64'd0);
      wait_counter(10, VA + 2, "tail");

      mon_en = 1'b0;
      flush_line();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
